// File: rtl/bram_2k_8bit_if.sv
// Bus bundle for one bram_2k_8bit tile: enable/write strobes, address, write data and registered read data.
// Port protocol: there is no valid/ready handshake. EN is the only qualifier. A cycle with EN=1
// is always accepted, and its read word is on data_out one clock later. A cycle with EN=0 is ignored.
interface bram_2k_8bit_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  EN;
  logic                  WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output EN,
    output WE,
    output ADDR,
    output data_in,
    input  data_out
  );

  modport slave (
    input  EN,
    input  WE,
    input  ADDR,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/bram_2k_8bit.sv
// Single-port synchronous block RAM tile (2**ADDR_WIDTH x DATA_WIDTH) with a registered read port.
// WRITE_MODE selects what data_out shows on a write: 0 old word, 1 new word, 2 hold.
module bram_2k_8bit #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int WRITE_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  bram_2k_8bit_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The array has no reset, and its only read is the registered one below. Keeping it that way
  // lets the tools map it onto a BRAM primitive. The declaration initialiser sets the power-up
  // contents to all zeros.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] dout_q;

  logic wr_fire;
  logic rd_update;

  assign wr_fire = bus.EN && bus.WE && !RST;

  // A NO_CHANGE write leaves the output register alone. Every other enabled cycle reloads it.
  assign rd_update = bus.EN && !((WRITE_MODE == 2) && bus.WE);

  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem[bus.ADDR] <= bus.data_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= '0;
    end else if (rd_update) begin
      if ((WRITE_MODE == 1) && bus.WE) begin
        dout_q <= bus.data_in;
      end else begin
        dout_q <= mem[bus.ADDR];
      end
    end
  end

  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_bram_2k_8bit.sv
// Self-checking bench for bram_2k_8bit: all three write modes run side by side from one stimulus
// stream against a reference model, and a four-tile 8K buffer is checked for bank aliasing.
module tb_bram_2k_8bit;
  localparam int AW = 11;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- single tiles, one per write mode ----------------
  bram_2k_8bit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_rf ();
  bram_2k_8bit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_wf ();
  bram_2k_8bit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_nc ();

  bram_2k_8bit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_MODE(0)) u_rf (.CLK(clk), .RST(rst), .bus(if_rf.slave));
  bram_2k_8bit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_MODE(1)) u_wf (.CLK(clk), .RST(rst), .bus(if_wf.slave));
  bram_2k_8bit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_MODE(2)) u_nc (.CLK(clk), .RST(rst), .bus(if_nc.slave));

  // ---------------- four-tile 8K buffer ----------------
  logic          buf_en;
  logic          buf_we;
  logic [12:0]   buf_addr;
  logic [DW-1:0] buf_din;
  logic [DW-1:0] bank_dout [4];
  logic [1:0]    sel_q;
  logic [DW-1:0] buf_dout;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_bank
      bram_2k_8bit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();
      assign bif.EN      = buf_en && (buf_addr[12:11] == 2'(g));
      assign bif.WE      = buf_we;
      assign bif.ADDR    = buf_addr[10:0];
      assign bif.data_in = buf_din;
      assign bank_dout[g] = bif.data_out;
      bram_2k_8bit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_MODE(0)) u_bank (
        .CLK (clk),
        .RST (rst),
        .bus (bif.slave)
      );
    end
  endgenerate

  always @(posedge clk) begin
    if (buf_en) sel_q <= buf_addr[12:11];
  end
  assign buf_dout = bank_dout[sel_q];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] rf_m, wf_m, nc_m;
  logic [3*DW-1:0] exp_q[$];

  // Drive one cycle on all three tiles and queue what each should show after the edge.
  task automatic cyc(input logic r, input logic en, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r;
    if_rf.EN = en; if_rf.WE = we; if_rf.ADDR = a; if_rf.data_in = d;
    if_wf.EN = en; if_wf.WE = we; if_wf.ADDR = a; if_wf.data_in = d;
    if_nc.EN = en; if_nc.WE = we; if_nc.ADDR = a; if_nc.data_in = d;
    if (r) begin
      rf_m = '0; wf_m = '0; nc_m = '0;
    end else if (en) begin
      if (we) begin
        rf_m = mem_m[a];
        wf_m = d;
        mem_m[a] = d;
      end else begin
        rf_m = mem_m[a];
        wf_m = mem_m[a];
        nc_m = mem_m[a];
      end
    end
    exp_q.push_back({rf_m, wf_m, nc_m});
  endtask

  always @(posedge clk) begin : monitor
    logic [3*DW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_dout", 32'(if_rf.data_out), 32'(e[23:16]));
      check("wf_dout", 32'(if_wf.data_out), 32'(e[15:8]));
      check("nc_dout", 32'(if_nc.data_out), 32'(e[7:0]));
    end
  end

  task automatic bank_cyc(input logic en, input logic we, input logic [12:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    buf_en = en; buf_we = we; buf_addr = a; buf_din = d;
  endtask

  // ---------------- stimulus ----------------
  logic [12:0]   baddr [4];
  logic [DW-1:0] bdata [4];

  initial begin
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    rf_m = '0; wf_m = '0; nc_m = '0;
    rst = 1'b1;
    buf_en = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_din = '0;
    if_rf.EN = 0; if_rf.WE = 0; if_rf.ADDR = '0; if_rf.data_in = '0;
    if_wf.EN = 0; if_wf.WE = 0; if_wf.ADDR = '0; if_wf.data_in = '0;
    if_nc.EN = 0; if_nc.WE = 0; if_nc.ADDR = '0; if_nc.data_in = '0;

    // Reset state, then reset overriding a write.
    cyc(1, 0, 0, 11'h000, 8'h00);
    cyc(1, 0, 0, 11'h000, 8'h00);
    cyc(0, 1, 1, 11'h009, 8'h77);
    cyc(0, 1, 0, 11'h009, 8'h00);
    cyc(1, 1, 1, 11'h005, 8'hAA);
    cyc(0, 1, 0, 11'h005, 8'h00);

    // Address extremes and back-to-back reads.
    cyc(0, 1, 1, 11'h000, 8'h3C);
    cyc(0, 1, 1, 11'h7FF, 8'hC3);
    cyc(0, 1, 1, 11'h400, 8'h5A);
    cyc(0, 1, 0, 11'h000, 8'h00);
    cyc(0, 1, 0, 11'h7FF, 8'h00);
    cyc(0, 1, 0, 11'h400, 8'h00);

    // Disabled cycles with a write pending on the bus must change nothing.
    repeat (5) cyc(0, 0, 1, 11'h000, 8'hFF);
    cyc(0, 1, 0, 11'h000, 8'h00);

    // Write-cycle output behaviour, then read-after-write.
    cyc(0, 1, 1, 11'h123, 8'h11);
    cyc(0, 1, 1, 11'h123, 8'h22);
    cyc(0, 1, 0, 11'h123, 8'h00);

    // Random traffic; a narrow address window half the time forces read-after-write hits.
    for (int i = 0; i < 10000; i++) begin
      logic r, en, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 2**AW - 1));
      d  = DW'($urandom_range(0, 255));
      if (!en && ($urandom_range(0, 1) == 0)) begin
        we = 1'bx; a = 'x; d = 'x;
      end
      cyc(r, en, we, a, d);
    end
    cyc(0, 0, 0, 11'h000, 8'h00);
    repeat (3) @(negedge clk);
    check("q_drain", 32'(exp_q.size()), 32'd0);

    // Four-tile buffer: same low address in every bank, distinct data.
    baddr[0] = 13'h0010; baddr[1] = 13'h0810; baddr[2] = 13'h1010; baddr[3] = 13'h1810;
    bdata[0] = 8'hA1;    bdata[1] = 8'hB2;    bdata[2] = 8'hC3;    bdata[3] = 8'hD4;
    for (int i = 0; i < 4; i++) bank_cyc(1, 1, baddr[i], bdata[i]);
    for (int i = 0; i < 4; i++) begin
      bank_cyc(1, 0, baddr[i], 8'h00);
      @(posedge clk);
      #1;
      check("bank_rd", 32'(buf_dout), 32'(bdata[i]));
    end
    bank_cyc(0, 0, 13'h0000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
